io_tx_buffer: RTL and testbench
===============================

IO_TX_BUFFER -- requirements
Module: io_tx_buffer

Interface
REQ-001 The block SHALL have these parameters, one per line:
  DEPTH_LOG2, default 4, log2 of the FIFO entry count (DEPTH = 16).
  FULL_MARGIN, default 2, free slots reserved for CPU writes already in flight.
REQ-002 The block SHALL have one clock and one reset: reset is asynchronous and active-low. Ports are listed below as name, direction, width, meaning.
  clk  input  1  system clock; all state updates on the rising edge.
  rst  input  1  asynchronous active-low reset.
  mem_a  input  32  CPU address bus.
  mem_dout  input  8  CPU write data.
  mem_wr  input  1  CPU write strobe (1 = write).
  io_buffer_full  output  1  backpressure to the CPU.
  tx_valid  output  1  head byte available for the UART transmitter.
  tx_data  output  8  head byte.
  tx_ready  input  1  UART transmitter accepts tx_data this cycle.
  program_done  output  1  stop terminator fully drained.
  drop_count  output  8  saturating count of bytes lost to overflow.

Function
REQ-003 An I/O write is a cycle with mem_wr=1 and mem_a[17:16]=2'b11; all other cycles SHALL be ignored.
REQ-004 An I/O write with mem_a[2:0]=0 and mem_dout≠0x00 SHALL request a push of mem_dout.
REQ-005 An I/O write with mem_a[2:0]=0 and mem_dout=0x00 SHALL be ignored.
REQ-006 An I/O write with mem_a[2:0]=4 SHALL request a push of the terminator 0x00 and set the internal stopped flag.
REQ-007 While stopped=1, all further I/O writes SHALL be ignored until reset.
REQ-008 The FIFO SHALL be circular, DEPTH entries of 8 bits, with head/tail pointers of width DEPTH_LOG2 that wrap modulo DEPTH, and a count of width DEPTH_LOG2+1.
REQ-009 A pop SHALL occur when tx_valid=1 and tx_ready=1; the head pointer advances and the count decrements.
REQ-010 A push SHALL be accepted when count<DEPTH, or when a pop occurs in the same cycle.
REQ-011 A simultaneous push and pop SHALL leave the count unchanged.
REQ-012 A push request that is not accepted SHALL be discarded; drop_count increments and saturates at 255.
REQ-013 A discarded terminator push SHALL still set stopped.
REQ-014 tx_valid SHALL equal (count≠0), and tx_data SHALL equal the head entry, both driven from registered state only.
REQ-015 A byte pushed in cycle N SHALL first be visible at tx_valid/tx_data in cycle N+1 when the FIFO was empty.
REQ-016 tx_data SHALL hold steady while tx_valid=1 and tx_ready=0.
REQ-017 io_buffer_full SHALL be registered and equal 1 in cycle N+1 iff the next count ≥ DEPTH−FULL_MARGIN.
REQ-018 The terminator SHALL be tracked by a pending-stop mark on its FIFO slot; the pop of that slot SHALL set program_done in the following cycle.
REQ-019 program_done SHALL remain 1 until reset.
REQ-020 If the terminator was discarded, program_done SHALL assert the cycle after the FIFO next becomes empty.
REQ-021 Control state SHALL be the three states RUN, DRAIN and DONE.
  RUN to DRAIN when stopped is set.
  DRAIN to DONE on the terminator pop, or on empty under REQ-020.
  DONE is terminal.

Reset
REQ-022 When rst=0 the block SHALL asynchronously clear the pointers, count, stopped, drop_count and FSM (to RUN). Resulting outputs: tx_valid=0, tx_data=0x00, io_buffer_full=0, program_done=0, drop_count=0.
REQ-023 FIFO storage contents SHALL need no reset.
REQ-024 Reset asserted mid-operation SHALL discard all queued bytes with no tx handshake completed in that cycle.
REQ-025 Writes and pops SHALL take effect only on rising edges with rst=1.

Verification
REQ-026 Basic push/pop: tx_ready=1; write 0x41 to 0x30000 in cycle 0 -> tx_valid=1 with tx_data=0x41 in cycle 1, tx_valid=0 in cycle 2.
REQ-027 Zero filter: write 0x00 to 0x30000 -> no push, count stays 0, program_done stays 0.
REQ-028 Fill and overflow: tx_ready=0; write 0x01..0x12 (18 bytes) -> io_buffer_full=1 after the 14th write, 16 entries held, drop_count=2. Then tx_ready=1 -> bytes 0x01..0x10 emerge in order.
REQ-029 Full-with-pop: FIFO full, tx_ready=1, one write in the same cycle -> push accepted, count stays 16, drop_count unchanged.
REQ-030 Stop sequence: write 0x61 and 0x62 to 0x30000, then any value to 0x30004, then 0x63 to 0x30000 -> tx stream is 0x61, 0x62, 0x00. 0x63 never appears. program_done=1 the cycle after the 0x00 pop.
REQ-031 Async reset: drive rst=0 mid-clock with 5 bytes queued -> tx_valid=0 and io_buffer_full=0 immediately, without a clock edge. After release, the FIFO is empty.

Source files
------------

// File: rtl/io_tx_buffer_if.sv
// io_tx_buffer_if
//   Groups the CPU write bus and the UART transmit handshake of io_tx_buffer.
//   slave  : the buffer (samples CPU bus and tx_ready, drives status and tx byte)
//   master : the environment (CPU side plus UART transmitter)
//   mem_a/mem_dout/mem_wr : CPU address, write data, write strobe
//   io_buffer_full        : backpressure to the CPU
//   tx_valid/tx_data/tx_ready : head byte handshake to the transmitter
//   program_done/drop_count   : stop terminator drained / overflow byte count
interface io_tx_buffer_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_done;
  logic [7:0]  drop_count;

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready,
    output io_buffer_full, tx_valid, tx_data, program_done, drop_count
  );

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready,
    input  io_buffer_full, tx_valid, tx_data, program_done, drop_count
  );
endinterface

// File: rtl/io_tx_buffer.sv
// io_tx_buffer
//   Circular byte FIFO between CPU I/O writes and a UART transmitter.
//   Writes to offset 0 queue non-zero bytes; a write to offset 4 queues a
//   0x00 terminator and stops further intake. program_done rises once the
//   terminator has been transmitted (or, if it was dropped, once the FIFO
//   drains).
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-low reset
//     bus : io_tx_buffer_if.slave (CPU bus, tx handshake, status)
module io_tx_buffer #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  io_tx_buffer_if.slave     bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_FULL_TH = CW'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH-1:0]      r_mark;
  logic [DEPTH_LOG2-1:0] r_head, r_tail;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_full;
  logic [7:0]            r_drop;
  logic                  r_stopped;
  logic                  r_stop_lost;
  state_t                r_state, w_state_nxt;

  logic       w_io_wr, w_is_data, w_is_stop, w_push_req, w_push_ok, w_pop;
  logic       w_term_pop;
  logic [7:0] w_push_byte;
  logic       w_unused_addr;

  assign w_unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

  assign w_io_wr     = bus.mem_wr && (bus.mem_a[17:16] == 2'b11) && !r_stopped;
  assign w_is_data   = (bus.mem_a[2:0] == 3'd0) && (bus.mem_dout != 8'h00);
  assign w_is_stop   = (bus.mem_a[2:0] == 3'd4);
  assign w_push_req  = w_io_wr && (w_is_data || w_is_stop);
  assign w_push_byte = w_is_stop ? 8'h00 : bus.mem_dout;
  assign w_pop       = (r_count != '0) && bus.tx_ready;
  assign w_push_ok   = w_push_req && ((r_count < C_DEPTH) || w_pop);
  assign w_term_pop  = w_pop && r_mark[r_head];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // Storage and per-slot stop marks; every push rewrites the mark so stale
  // marks from earlier laps never survive.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_tail]  <= w_push_byte;
      r_mark[r_tail] <= w_is_stop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_drop      <= '0;
      r_stopped   <= 1'b0;
      r_stop_lost <= 1'b0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + DEPTH_LOG2'(1);
      if (w_pop)     r_head <= r_head + DEPTH_LOG2'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt >= C_FULL_TH);
      if (w_push_req && !w_push_ok && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
      // A dropped terminator still stops intake; remember it so the FSM
      // can finish on empty instead of waiting for a marked slot.
      if (w_io_wr && w_is_stop) begin
        r_stopped <= 1'b1;
        if (!w_push_ok) r_stop_lost <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  // The terminator can be popped the cycle after it is pushed, while the
  // state is still RUN, so a terminator pop finishes from RUN as well.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_term_pop)     w_state_nxt = S_DONE;
        else if (r_stopped) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_term_pop || (r_stop_lost && (r_count == '0)))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign bus.tx_valid       = (r_count != '0);
  assign bus.tx_data        = (r_count != '0) ? r_mem[r_head] : 8'h00;
  assign bus.io_buffer_full = r_full;
  assign bus.drop_count     = r_drop;
  assign bus.program_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_io_tx_buffer.sv
module tb_io_tx_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  io_tx_buffer_if bus ();

  io_tx_buffer #(.DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb [$];
  logic [7:0]  mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every completed handshake is checked against the queue.
  always @(negedge clk) begin
    if (rst && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %02h expected none (t=%0t)", bus.tx_data, $time);
      end else begin
        mon_exp = sb.pop_front();
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, mon_exp});
        if (mon_exp == 8'h00) begin
          chk("done_at_term_pop", {31'd0, bus.program_done}, 32'd0);
          @(negedge clk);
          chk("done_after_term_pop", {31'd0, bus.program_done}, 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_wr   = 1'b0;
    bus.mem_a    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    bus.tx_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'd0, bus.tx_data}, 32'd0);
    chk("rst_full",     {31'd0, bus.io_buffer_full}, 32'd0);
    chk("rst_done",     {31'd0, bus.program_done}, 32'd0);
    chk("rst_drop",     {24'd0, bus.drop_count}, 32'd0);
    do_reset();

    // Basic push/pop latency
    bus.tx_ready = 1'b1;
    sb.push_back(8'h41);
    wr(32'h0003_0000, 8'h41);
    @(negedge clk);
    chk("basic_valid_c1", {31'd0, bus.tx_valid}, 32'd1);
    chk("basic_data_c1",  {24'd0, bus.tx_data}, 32'h41);
    step();
    @(negedge clk);
    chk("basic_valid_c2", {31'd0, bus.tx_valid}, 32'd0);
    step();

    // Ignored writes: zero data, non-I/O address, unused offset
    wr(32'h0003_0000, 8'h00);
    wr(32'h0002_0000, 8'h55);
    wr(32'h0003_0001, 8'h56);
    @(negedge clk);
    chk("zero_filter_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("zero_filter_done",  {31'd0, bus.program_done}, 32'd0);
    step();

    // Fill and overflow
    bus.tx_ready = 1'b0;
    for (int unsigned k = 1; k <= 18; k++) begin
      if (k <= 16) sb.push_back(8'(k));
      wr(32'h0003_0000, 8'(k));
      chk($sformatf("full_after_%0d", k), {31'd0, bus.io_buffer_full},
          ((k >= 14) ? 32'd1 : 32'd0));
    end
    chk("overflow_drop", {24'd0, bus.drop_count}, 32'd2);

    // Full with simultaneous pop
    bus.tx_ready = 1'b1;
    sb.push_back(8'h13);
    wr(32'h0003_0000, 8'h13);
    chk("fullpop_full", {31'd0, bus.io_buffer_full}, 32'd1);
    chk("fullpop_drop", {24'd0, bus.drop_count}, 32'd2);
    wait_empty("fill_drain_timeout");
    chk("fill_sb_empty", sb.size(), 32'd0);
    chk("drained_full",  {31'd0, bus.io_buffer_full}, 32'd0);
    step();

    // Stop sequence
    sb.push_back(8'h61);
    sb.push_back(8'h62);
    sb.push_back(8'h00);
    wr(32'h0003_0000, 8'h61);
    wr(32'h0003_0000, 8'h62);
    wr(32'h0003_0004, 8'hAA);
    wr(32'h0003_0000, 8'h63);
    repeat (6) step();
    chk("stop_sb_empty", sb.size(), 32'd0);
    wr(32'h0003_0000, 8'h55);
    @(negedge clk);
    chk("stopped_ignores_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("done_sticky", {31'd0, bus.program_done}, 32'd1);
    step();

    // Terminator dropped on a full FIFO: done follows the drain
    do_reset();
    chk("rst2_done", {31'd0, bus.program_done}, 32'd0);
    bus.tx_ready = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      sb.push_back(8'(8'h80 + k));
      wr(32'h0003_0000, 8'(8'h80 + k));
    end
    wr(32'h0003_0004, 8'h00);
    chk("lost_term_drop", {24'd0, bus.drop_count}, 32'd1);
    bus.tx_ready = 1'b1;
    wait_empty("lost_drain_timeout");
    chk("lost_done_at_empty", {31'd0, bus.program_done}, 32'd0);
    @(negedge clk);
    chk("lost_done_after_empty", {31'd0, bus.program_done}, 32'd1);
    chk("lost_sb_empty", sb.size(), 32'd0);
    step();

    // Asynchronous reset with bytes queued
    do_reset();
    bus.tx_ready = 1'b0;
    for (int unsigned k = 0; k < 14; k++) begin
      sb.push_back(8'(8'hA0 + k));
      wr(32'h0003_0000, 8'(8'hA0 + k));
    end
    chk("pre_arst_valid", {31'd0, bus.tx_valid}, 32'd1);
    chk("pre_arst_full",  {31'd0, bus.io_buffer_full}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("arst_full",  {31'd0, bus.io_buffer_full}, 32'd0);
    chk("arst_data",  {24'd0, bus.tx_data}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("post_arst_valid", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b1;
    sb.push_back(8'h77);
    wr(32'h0003_0000, 8'h77);
    wait_empty("post_arst_timeout");
    chk("post_arst_sb_empty", sb.size(), 32'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
